// File: rtl/pong_pkg.sv
//------------------------------------------------------------------------------
// Module  : pong_pkg
// Brief   : Shared state encodings, screen geometry and game constants for pong.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pong_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SERVE  = 3'd1,
        S_PLAY   = 3'd2,
        S_SCORED = 3'd3,
        S_OVER   = 3'd4
    } game_state_t;

    // Geometry is 11 bits wide so that ball_x + BALL_SIZE can never wrap.
    localparam logic [10:0] SCREEN_W    = 11'd640;
    localparam logic [10:0] SCREEN_H    = 11'd480;
    localparam logic [10:0] WALL_TOP    = 11'd0;
    localparam logic [10:0] WALL_BOTTOM = 11'd400;
    localparam logic [10:0] BALL_SIZE   = 11'd16;
    localparam logic [10:0] PADDLE_LX   = 11'd16;
    localparam logic [10:0] PADDLE_RX   = 11'd608;
    localparam logic [10:0] PADDLE_H    = 11'd64;

    localparam logic [9:0]  TICK_LINE    = 10'd480;
    localparam logic [7:0]  SERVE_FRAMES = 8'd60;
    localparam logic [3:0]  WIN_SCORE    = 4'd9;
    localparam logic [7:0]  HITS_PER_UP  = 8'd4;
    localparam logic [2:0]  MAX_SPEED    = 3'd4;

    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

endpackage

`default_nettype wire

// File: rtl/pong_frame_tick.sv
//------------------------------------------------------------------------------
// Module  : pong_frame_tick
// Brief   : Registered one-cycle frame tick when the scan reaches (0, TICK_LINE).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pong_frame_tick #(
    parameter logic [9:0] TICK_LINE = 10'd480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] counter_x,
    input  logic [9:0] counter_y,
    output logic       frame_tick
);

    logic r_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= (counter_x == 10'd0) && (counter_y == TICK_LINE);
        end
    end

    assign frame_tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/pong_game_ctrl.sv
//------------------------------------------------------------------------------
// Module  : pong_game_ctrl
// Brief   : Pong sequencer: serve/play/score/over FSM, collisions and scores.
//           Define SPEEDUP_EN to raise ball speed with paddle hits.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pong_game_ctrl
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] counter_x,
    input  logic [9:0] counter_y,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [9:0] paddle_ly,
    input  logic [9:0] paddle_ry,
    output logic       ball_load,
    output logic       ball_step,
    output logic       ball_dir_x,
    output logic       ball_dir_y,
    output logic [2:0] ball_speed,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [2:0] game_state,
    output logic       game_over
);

    logic        w_frame_tick;
    game_state_t r_state, w_state_n;
    logic        r_start_d, w_start_rise;
    logic        r_load, w_load_n, r_step, w_step_n;
    logic        r_dir_x, w_dir_x_n, r_dir_y, w_dir_y_n;
    logic [3:0]  r_score_l, w_score_l_n, r_score_r, w_score_r_n, w_new_score;
    logic [7:0]  r_frames, w_frames_n;
    logic        r_scorer_r, w_scorer_r_n;
    logic [2:0]  w_speed;
    logic [10:0] w_bx, w_by, w_bx_end, w_by_end, w_ply, w_pry;
    logic        w_top, w_bottom, w_hit_l, w_hit_r, w_miss_l, w_miss_r;

    pong_frame_tick #(
        .TICK_LINE (TICK_LINE)
    ) u_frame_tick (
        .clk        (clk),
        .rst        (rst),
        .counter_x  (counter_x),
        .counter_y  (counter_y),
        .frame_tick (w_frame_tick)
    );

    assign w_start_rise = start & ~r_start_d;

    assign w_bx     = {1'b0, ball_x};
    assign w_by     = {1'b0, ball_y};
    assign w_ply    = {1'b0, paddle_ly};
    assign w_pry    = {1'b0, paddle_ry};
    assign w_bx_end = w_bx + BALL_SIZE;
    assign w_by_end = w_by + BALL_SIZE;

    assign w_top    = (w_by <= WALL_TOP);
    assign w_bottom = (w_by_end >= WALL_BOTTOM);
    assign w_hit_l  = (r_dir_x == DIR_NEG) && (w_bx <= PADDLE_LX) &&
                      (w_by_end > w_ply) && (w_by < w_ply + PADDLE_H);
    assign w_hit_r  = (r_dir_x == DIR_POS) && (w_bx_end >= PADDLE_RX) &&
                      (w_by_end > w_pry) && (w_by < w_pry + PADDLE_H);
    // A paddle hit always beats a miss on the same tick.
    assign w_miss_l = !(w_hit_l || w_hit_r) && (w_bx <= {8'd0, w_speed});
    assign w_miss_r = !(w_hit_l || w_hit_r) && (w_bx_end >= SCREEN_W - {8'd0, w_speed});

    assign w_new_score = (r_scorer_r ? r_score_r : r_score_l) + 4'd1;

`ifdef SPEEDUP_EN
    logic [2:0] r_speed, w_speed_n;
    logic [7:0] r_hits, w_hits_n;
    assign w_speed = r_speed;
`else
    assign w_speed = 3'd1;
`endif

    always_comb begin
        w_state_n    = r_state;
        w_load_n     = 1'b0;
        w_step_n     = 1'b0;
        w_dir_x_n    = r_dir_x;
        w_dir_y_n    = r_dir_y;
        w_score_l_n  = r_score_l;
        w_score_r_n  = r_score_r;
        w_frames_n   = r_frames;
        w_scorer_r_n = r_scorer_r;
`ifdef SPEEDUP_EN
        w_speed_n    = r_speed;
        w_hits_n     = r_hits;
`endif
        case (r_state)
            S_IDLE, S_OVER: begin
                if (w_start_rise) begin
                    w_score_l_n = 4'd0;
                    w_score_r_n = 4'd0;
                    w_load_n    = 1'b1;
                    w_frames_n  = 8'd0;
                    w_state_n   = S_SERVE;
`ifdef SPEEDUP_EN
                    w_speed_n   = 3'd1;
                    w_hits_n    = 8'd0;
`endif
                end
            end
            S_SERVE: begin
                if (w_frame_tick) begin
                    if (r_frames == SERVE_FRAMES - 8'd1) begin
                        w_frames_n = 8'd0;
                        w_state_n  = S_PLAY;
                    end else begin
                        w_frames_n = r_frames + 8'd1;
                    end
                end
            end
            S_PLAY: begin
                if (w_frame_tick) begin
                    if (w_top)    w_dir_y_n = DIR_POS;
                    if (w_bottom) w_dir_y_n = DIR_NEG;
                    if (w_hit_l)  w_dir_x_n = DIR_POS;
                    if (w_hit_r)  w_dir_x_n = DIR_NEG;
`ifdef SPEEDUP_EN
                    if (w_hit_l || w_hit_r) begin
                        if (r_hits == HITS_PER_UP - 8'd1) begin
                            w_hits_n = 8'd0;
                            if (r_speed < MAX_SPEED) w_speed_n = r_speed + 3'd1;
                        end else begin
                            w_hits_n = r_hits + 8'd1;
                        end
                    end
`endif
                    if (w_miss_l || w_miss_r) begin
                        w_scorer_r_n = w_miss_l;
                        w_state_n    = S_SCORED;
                    end else begin
                        w_step_n = 1'b1;
                    end
                end
            end
            S_SCORED: begin
                if (r_scorer_r) w_score_r_n = w_new_score;
                else            w_score_l_n = w_new_score;
                if (w_new_score == WIN_SCORE) begin
                    w_state_n = S_OVER;
                end else begin
                    // Serve toward the player who just conceded.
                    w_load_n   = 1'b1;
                    w_dir_x_n  = r_scorer_r ? DIR_NEG : DIR_POS;
                    w_dir_y_n  = DIR_POS;
                    w_frames_n = 8'd0;
                    w_state_n  = S_SERVE;
`ifdef SPEEDUP_EN
                    w_speed_n  = 3'd1;
                    w_hits_n   = 8'd0;
`endif
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // Tracks start during reset too, so a held button cannot start a game on release.
        r_start_d <= start;
        if (rst) begin
            r_state    <= S_IDLE;
            r_load     <= 1'b0;
            r_step     <= 1'b0;
            r_dir_x    <= DIR_POS;
            r_dir_y    <= DIR_POS;
            r_score_l  <= 4'd0;
            r_score_r  <= 4'd0;
            r_frames   <= 8'd0;
            r_scorer_r <= 1'b0;
`ifdef SPEEDUP_EN
            r_speed    <= 3'd1;
            r_hits     <= 8'd0;
`endif
        end else begin
            r_state    <= w_state_n;
            r_load     <= w_load_n;
            r_step     <= w_step_n;
            r_dir_x    <= w_dir_x_n;
            r_dir_y    <= w_dir_y_n;
            r_score_l  <= w_score_l_n;
            r_score_r  <= w_score_r_n;
            r_frames   <= w_frames_n;
            r_scorer_r <= w_scorer_r_n;
`ifdef SPEEDUP_EN
            r_speed    <= w_speed_n;
            r_hits     <= w_hits_n;
`endif
        end
    end

    assign ball_load  = r_load;
    assign ball_step  = r_step;
    assign ball_dir_x = r_dir_x;
    assign ball_dir_y = r_dir_y;
    assign ball_speed = w_speed;
    assign score_l    = r_score_l;
    assign score_r    = r_score_r;
    assign game_state = r_state;
    assign game_over  = (r_state == S_OVER);

endmodule

`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_pong_game_ctrl
// Brief   : Directed self-checking bench for pong_game_ctrl.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [9:0] counter_x, counter_y, ball_x, ball_y, paddle_ly, paddle_ry;
    logic       ball_load, ball_step, ball_dir_x, ball_dir_y, game_over;
    logic [2:0] ball_speed, game_state;
    logic [3:0] score_l, score_r;

    int errors = 0;
    int checks = 0;

    pong_game_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .counter_x  (counter_x),
        .counter_y  (counter_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .paddle_ly  (paddle_ly),
        .paddle_ry  (paddle_ry),
        .ball_load  (ball_load),
        .ball_step  (ball_step),
        .ball_dir_x (ball_dir_x),
        .ball_dir_y (ball_dir_y),
        .ball_speed (ball_speed),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_state (game_state),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame tick; returns at the falling edge where the tick's effects are visible.
    task automatic frame();
        @(negedge clk);
        counter_x = 10'd0;
        counter_y = 10'd480;
        @(negedge clk);
        counter_x = 10'd5;
        counter_y = 10'd1;
        @(negedge clk);
    endtask

    task automatic hit_pair();
        ball_x = 10'd592;
        frame();
        ball_x = 10'd10;
        frame();
    endtask

    task automatic point_left();
        ball_x = 10'd312;
        repeat (60) frame();
        ball_x = 10'd624;
        ball_y = 10'd300;
        frame();
        @(negedge clk);
        ball_x = 10'd312;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        counter_x = 10'd5; counter_y = 10'd1;
        ball_x = 10'd312; ball_y = 10'd200;
        paddle_ly = 10'd100; paddle_ry = 10'd100;
        repeat (3) @(negedge clk);
        check("rst_state", 16'(game_state), 16'd0);
        check("rst_load", 16'(ball_load), 16'd0);
        check("rst_step", 16'(ball_step), 16'd0);
        check("rst_dirx", 16'(ball_dir_x), 16'd0);
        check("rst_diry", 16'(ball_dir_y), 16'd0);
        check("rst_speed", 16'(ball_speed), 16'd1);
        check("rst_score_l", 16'(score_l), 16'd0);
        check("rst_score_r", 16'(score_r), 16'd0);
        check("rst_over", 16'(game_over), 16'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_hold", 16'(game_state), 16'd0);

        // Start and serve
        start = 1'b1;
        @(negedge clk);
        check("start_load", 16'(ball_load), 16'd1);
        check("start_state", 16'(game_state), 16'd1);
        @(negedge clk);
        check("load_pulse_end", 16'(ball_load), 16'd0);
        start = 1'b0;
        repeat (59) frame();
        check("serve_59", 16'(game_state), 16'd1);
        check("serve_nostep", 16'(ball_step), 16'd0);
        frame();
        check("serve_60", 16'(game_state), 16'd2);
        frame();
        check("play_step", 16'(ball_step), 16'd1);
        @(negedge clk);
        check("play_step_pulse", 16'(ball_step), 16'd0);

        // Walls
        ball_y = 10'd384;
        frame();
        check("bottom_diry", 16'(ball_dir_y), 16'd1);
        check("bottom_step", 16'(ball_step), 16'd1);
        ball_y = 10'd0;
        frame();
        check("top_diry", 16'(ball_dir_y), 16'd0);
        check("top_step", 16'(ball_step), 16'd1);

        // Paddles and a left miss
        ball_y = 10'd120; ball_x = 10'd592;
        frame();
        check("rhit_dirx", 16'(ball_dir_x), 16'd1);
        ball_x = 10'd10;
        frame();
        check("lhit_dirx", 16'(ball_dir_x), 16'd0);
        check("lhit_score_r", 16'(score_r), 16'd0);
        check("lhit_state", 16'(game_state), 16'd2);
        ball_x = 10'd592;
        frame();
        ball_y = 10'd200; ball_x = 10'd10;
        frame();
        check("lnohit_dirx", 16'(ball_dir_x), 16'd1);
        check("lnohit_state", 16'(game_state), 16'd2);
        ball_x = 10'd1;
        frame();
        check("miss_state", 16'(game_state), 16'd3);
        check("miss_nostep", 16'(ball_step), 16'd0);
        @(negedge clk);
        check("miss_score_r", 16'(score_r), 16'd1);
        check("miss_load", 16'(ball_load), 16'd1);
        check("miss_dirx", 16'(ball_dir_x), 16'd1);
        check("miss_diry", 16'(ball_dir_y), 16'd0);
        check("miss_serve", 16'(game_state), 16'd1);

        // Run left to a win
        for (int i = 1; i <= 8; i++) begin
            point_left();
            check("pt_score_l", 16'(score_l), 16'(i));
            check("pt_state", 16'(game_state), 16'd1);
        end
        point_left();
        check("win_score_l", 16'(score_l), 16'd9);
        check("win_score_r", 16'(score_r), 16'd1);
        check("win_state", 16'(game_state), 16'd4);
        check("win_over", 16'(game_over), 16'd1);
        check("win_noload", 16'(ball_load), 16'd0);
        repeat (3) frame();
        check("over_hold", 16'(score_l), 16'd9);
        start = 1'b1;
        @(negedge clk);
        check("restart_l", 16'(score_l), 16'd0);
        check("restart_r", 16'(score_r), 16'd0);
        check("restart_state", 16'(game_state), 16'd1);
        check("restart_load", 16'(ball_load), 16'd1);
        check("restart_over", 16'(game_over), 16'd0);
        start = 1'b0;

        // Speed behaviour with paddle hits
        repeat (60) frame();
        check("play2_state", 16'(game_state), 16'd2);
        ball_y = 10'd120;
        repeat (2) hit_pair();
`ifdef SPEEDUP_EN
        check("speed_4hits", 16'(ball_speed), 16'd2);
`else
        check("speed_4hits", 16'(ball_speed), 16'd1);
`endif
        repeat (6) hit_pair();
`ifdef SPEEDUP_EN
        check("speed_16hits", 16'(ball_speed), 16'd4);
`else
        check("speed_16hits", 16'(ball_speed), 16'd1);
`endif
        check("hits_dirx", 16'(ball_dir_x), 16'd0);
        ball_x = 10'd624; ball_y = 10'd300;
        frame();
        @(negedge clk);
        check("reserve_score_l", 16'(score_l), 16'd1);
        check("reserve_speed", 16'(ball_speed), 16'd1);
        check("reserve_load", 16'(ball_load), 16'd1);
        check("reserve_dirx", 16'(ball_dir_x), 16'd0);

        // Reset mid-play with start held
        ball_x = 10'd312;
        repeat (60) frame();
        ball_x = 10'd592; ball_y = 10'd384; paddle_ry = 10'd350;
        frame();
        check("both_dirx", 16'(ball_dir_x), 16'd1);
        check("both_diry", 16'(ball_dir_y), 16'd1);
        check("both_step", 16'(ball_step), 16'd1);
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        check("mid_rst_state", 16'(game_state), 16'd0);
        check("mid_rst_dirx", 16'(ball_dir_x), 16'd0);
        check("mid_rst_diry", 16'(ball_dir_y), 16'd0);
        check("mid_rst_score_l", 16'(score_l), 16'd0);
        check("mid_rst_step", 16'(ball_step), 16'd0);
        check("mid_rst_load", 16'(ball_load), 16'd0);
        check("mid_rst_speed", 16'(ball_speed), 16'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("held_start_state", 16'(game_state), 16'd0);
        check("held_start_load", 16'(ball_load), 16'd0);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("fresh_start", 16'(game_state), 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
